uart_loader: RTL and testbench
==============================

# uart_loader

Hardware boot loader that acts as the bus initiator for the board's UART register interface (a0/cs/rnw/din/dout), in place of the CPU. It polls the UART status, parses a simple load/go byte protocol, writes received bytes into memory through a byte-wide write port, and replies with ACK/NAK bytes through the UART transmitter. It sits between the UART and the memory arbiter on the microcomp board and holds the CPU in reset until a Go command is received.

## Interface

Parameters:
- TIMEOUT, 2080000: clk cycles allowed between bytes inside a frame (1 s at 2.08 MHz).
- CMD_LOAD, 8'h4C: load command byte ('L').
- CMD_GO, 8'h47: go command byte ('G').
- ACK, 8'h06: reply for success.
- NAK, 8'h15: reply for checksum failure.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- uart_cs  out  1  UART chip select.
- uart_rnw  out  1  UART read(1)/write(0).
- uart_a0  out  1  UART register select: 0 = status, 1 = data.
- uart_din  out  8  byte written to UART TX.
- uart_dout  in  8  UART read data: status {6'b0, tx_busy, rx_full} when a0=0, RX byte when a0=1; combinational on a0, independent of cs.
- mem_addr  out  16  memory write address.
- mem_dout  out  8  memory write data.
- mem_we  out  1  one-cycle write strobe.
- go  out  1  one-cycle pulse: start CPU.
- go_addr  out  16  CPU start address, held after go.
- busy  out  1  high while a frame is in progress (phase != CMD).

## Operation

- All outputs are registered. Reset values: uart_cs=0, uart_rnw=1, uart_a0=0, uart_din=0, mem_addr=0, mem_dout=0, mem_we=0, go=0, go_addr=0, busy=0; bus FSM in POLL, protocol phase in CMD, checksum=0, timeout counter=0.
- Bus FSM:
  - POLL: cs=0, a0=0. If uart_dout[0] (rx_full), go to RD.
  - RD: cs=0, rnw=1, a0=1. Capture uart_dout as rx_byte at the posedge ending this cycle. Go to CLR.
  - CLR: cs=1, rnw=1, a0=1 for exactly one cycle. The UART clears rx_full on its negedge. Go to PARSE.
  - PARSE: cs=0. Apply rx_byte to the protocol, then go to TXWAIT if a reply is due, else POLL.
  - TXWAIT: cs=0, a0=0. Wait until uart_dout[1] (tx_busy) = 0, then go to TXWR.
  - TXWR: cs=1, rnw=0, a0=1, uart_din=reply for one cycle. Go to POLL, or to GO if a Go reply was sent.
  - GO: go=1 for one cycle. Go to POLL.
- The RX byte is captured with cs low, because the UART discards its RX byte on the same cycle cs is asserted with a0=1.
- Protocol phases, advanced only in PARSE:
  - CMD:
    - CMD_LOAD → AH.
    - CMD_GO → GH.
    - Any other byte is ignored and the phase stays CMD, with no reply.
  - AH/AL: load the address high byte, then the low byte. After AL, the phase goes to LEN.
  - LEN: count = byte, where 0 means 256. Clear the checksum. Go to DATA.
  - DATA:
    - mem_we=1 for one cycle with mem_addr=addr, mem_dout=byte.
    - addr += 1, wrapping mod 2^16.
    - checksum += byte, mod 256.
    - count -= 1. When count reaches 0, go to SUM.
  - SUM: reply ACK if the byte equals the checksum, else NAK. Memory is already written either way. Go to CMD.
  - GH/GL: load go_addr high, then low. After GL, reply ACK; after TXWR, pulse go. Go to CMD.
- Timeout:
  - The counter runs only while phase != CMD and the bus FSM is in POLL.
  - It is cleared on every captured byte.
  - On reaching TIMEOUT-1, the phase returns to CMD, with no reply and no memory write.
- busy = (phase != CMD), registered.

## Timing

- Byte to memory write: rx_full seen in POLL at cycle n; RD is n+1, CLR n+2, PARSE n+3. mem_we is high during cycle n+4.
- The reply is written no earlier than 2 cycles after PARSE (TXWAIT, then TXWR). It waits indefinitely on tx_busy.
- go rises the cycle after TXWR of the Go ACK. go_addr is stable from PARSE of GL onward.
- A byte arriving while the FSM is in TXWAIT/TXWR stays latched in the UART and is picked up at the next POLL.
- Reset asserted mid-frame: all outputs go immediately to their reset values. A partially written block is left as is.
- mem_we and uart_cs are never high in the same cycle.

## Test plan

- Load frame 4C 12 34 03 AA BB CC 31 → writes 12_34=AA, 12_35=BB, 12_36=CC, each mem_we one cycle wide; TX byte 06; busy returns to 0.
- Same frame with checksum 00 → the same three writes; TX byte 15.
- Wrap and LEN=0: 4C FF FF 00 followed by 256 bytes of 01, checksum 00 → 256 writes, addresses FFFF then 0000..00FE; reply 06.
- Go: 47 80 00 → TX 06, then go pulses exactly one cycle with go_addr=8000.
- Timeout: 4C 12, then idle for TIMEOUT cycles, then 47 00 10 → no reply to the partial frame; Go executes with go_addr=0010.
- Junk and reset: byte 00 → no TX, busy stays 0. Then send 4C 00 00 05 01 and assert reset → all outputs at reset values; the next 47 00 00 gives reply 06.

Source files
------------

// File: rtl/uart_loader.sv
// uart_loader: boot loader acting as bus initiator on the UART register port.
// Polls UART status, parses the load/go byte protocol, writes payload bytes to
// memory and answers with ACK/NAK. Go command pulses `go` with go_addr held.
//
// Bus FSM
//   state    | meaning
//   POLL     | watch rx_full on the status register
//   RD       | a0=1 with cs low, capture RX byte
//   CLR      | cs=1 read strobe so the UART drops rx_full
//   PARSE    | apply captured byte to the protocol phase
//   TXWAIT   | watch tx_busy before writing a reply
//   TXWR     | cs=1 write strobe with the reply byte
//   GO       | one-cycle go pulse after the Go ACK
//
// Protocol phase
//   phase    | meaning
//   CMD      | waiting for a command byte
//   AH/AL    | load address high/low
//   LEN      | byte count, 0 = 256
//   DATA     | payload bytes to memory
//   SUM      | checksum byte, reply ACK/NAK
//   GH/GL    | go address high/low

module uart_loader #(
   parameter int          TIMEOUT  = 2080000,
   parameter logic [7:0]  CMD_LOAD = 8'h4C,
   parameter logic [7:0]  CMD_GO   = 8'h47,
   parameter logic [7:0]  ACK      = 8'h06,
   parameter logic [7:0]  NAK      = 8'h15
) (
   input  logic        clk,
   input  logic        reset,
   output logic        uart_cs,
   output logic        uart_rnw,
   output logic        uart_a0,
   output logic [7:0]  uart_din,
   input  logic [7:0]  uart_dout,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_dout,
   output logic        mem_we,
   output logic        go,
   output logic [15:0] go_addr,
   output logic        busy
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_POLL, S_RD, S_CLR, S_PARSE, S_TXWAIT, S_TXWR, S_GO
   } bus_t;

   typedef enum logic [2:0] {
      P_CMD, P_AH, P_AL, P_LEN, P_DATA, P_SUM, P_GH, P_GL
   } phase_t;

   bus_t          state, state_nxt;
   phase_t        phase;
   logic [7:0]    rx_byte;
   logic [7:0]    csum;
   logic [7:0]    reply;
   logic [15:0]   addr;
   logic [8:0]    count;
   logic          go_due;
   logic [TW-1:0] tmo_cnt;
   logic          reply_due;
   logic          cs_nxt, rnw_nxt, a0_nxt, go_nxt;

   // Only the checksum byte and the go-address low byte produce a reply.
   assign reply_due = (phase == P_SUM) || (phase == P_GL);

   // Bus state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_POLL;
      else        state <= state_nxt;
   end

   // Bus next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         S_POLL:   if (uart_dout[0]) state_nxt = S_RD;
         S_RD:     state_nxt = S_CLR;
         S_CLR:    state_nxt = S_PARSE;
         S_PARSE:  state_nxt = reply_due ? S_TXWAIT : S_POLL;
         S_TXWAIT: if (!uart_dout[1]) state_nxt = S_TXWR;
         S_TXWR:   state_nxt = go_due ? S_GO : S_POLL;
         S_GO:     state_nxt = S_POLL;
         default:  state_nxt = S_POLL;
      endcase
   end

   // Bus output decode from the upcoming state, so registered outputs line up with it
   always_comb begin
      cs_nxt  = (state_nxt == S_CLR) || (state_nxt == S_TXWR);
      rnw_nxt = (state_nxt != S_TXWR);
      a0_nxt  = (state_nxt == S_RD) || (state_nxt == S_CLR) || (state_nxt == S_TXWR);
      go_nxt  = (state_nxt == S_GO);
   end

   // Bus output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         uart_cs  <= 1'b0;
         uart_rnw <= 1'b1;
         uart_a0  <= 1'b0;
         uart_din <= 8'h00;
         go       <= 1'b0;
      end else begin
         uart_cs  <= cs_nxt;
         uart_rnw <= rnw_nxt;
         uart_a0  <= a0_nxt;
         go       <= go_nxt;
         if (state_nxt == S_TXWR) uart_din <= reply;
      end
   end

   // Protocol datapath: byte capture, phase sequencing, memory writes, inter-byte timeout
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase    <= P_CMD;
         rx_byte  <= 8'h00;
         csum     <= 8'h00;
         reply    <= 8'h00;
         addr     <= 16'h0000;
         count    <= 9'd0;
         go_due   <= 1'b0;
         tmo_cnt  <= '0;
         mem_addr <= 16'h0000;
         mem_dout <= 8'h00;
         mem_we   <= 1'b0;
         go_addr  <= 16'h0000;
         busy     <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         busy   <= (phase != P_CMD);

         // Capture happens while cs is still low; the CLR strobe would discard the byte.
         if (state == S_RD) begin
            rx_byte <= uart_dout;
            tmo_cnt <= '0;
         end else if (state == S_POLL && phase != P_CMD) begin
            if (tmo_cnt == TW'(TIMEOUT - 1)) begin
               phase   <= P_CMD;
               tmo_cnt <= '0;
            end else begin
               tmo_cnt <= tmo_cnt + TW'(1);
            end
         end

         if (state == S_PARSE) begin
            case (phase)
               P_CMD: begin
                  if (rx_byte == CMD_LOAD)    phase <= P_AH;
                  else if (rx_byte == CMD_GO) phase <= P_GH;
               end
               P_AH: begin
                  addr[15:8] <= rx_byte;
                  phase      <= P_AL;
               end
               P_AL: begin
                  addr[7:0] <= rx_byte;
                  phase     <= P_LEN;
               end
               P_LEN: begin
                  count <= (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
                  csum  <= 8'h00;
                  phase <= P_DATA;
               end
               P_DATA: begin
                  mem_we   <= 1'b1;
                  mem_addr <= addr;
                  mem_dout <= rx_byte;
                  addr     <= addr + 16'd1;
                  csum     <= csum + rx_byte;
                  count    <= count - 9'd1;
                  if (count == 9'd1) phase <= P_SUM;
               end
               P_SUM: begin
                  reply  <= (rx_byte == csum) ? ACK : NAK;
                  go_due <= 1'b0;
                  phase  <= P_CMD;
               end
               P_GH: begin
                  go_addr[15:8] <= rx_byte;
                  phase         <= P_GL;
               end
               P_GL: begin
                  go_addr[7:0] <= rx_byte;
                  reply        <= ACK;
                  go_due       <= 1'b1;
                  phase        <= P_CMD;
               end
               default: phase <= P_CMD;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: behavioural UART register model, directed protocol
// scenarios from the block description and randomized load frames checked
// against an arithmetic model of address/checksum rules.
module tb_uart_loader;

   localparam int TMO = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        uart_cs, uart_rnw, uart_a0;
   logic [7:0]  uart_din, uart_dout;
   logic [15:0] mem_addr, go_addr;
   logic [7:0]  mem_dout;
   logic        mem_we, go, busy;

   int checks = 0;
   int failures = 0;

   uart_loader #(.TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .uart_cs(uart_cs), .uart_rnw(uart_rnw), .uart_a0(uart_a0),
      .uart_din(uart_din), .uart_dout(uart_dout),
      .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_we(mem_we),
      .go(go), .go_addr(go_addr), .busy(busy)
   );

   always #5 clk = ~clk;

   // UART model: rx_full set by the stimulus, cleared by a cs read of the data register
   logic [7:0]  rx_data = 8'h00;
   int          rx_set = 0;
   int          rx_clr = 0;
   int          tx_busy_cnt = 0;
   logic        rx_full, tx_busy;
   assign rx_full   = (rx_set != rx_clr);
   assign tx_busy   = (tx_busy_cnt != 0);
   assign uart_dout = uart_a0 ? rx_data : {6'b0, tx_busy, rx_full};

   logic [7:0]  tx_q[$];
   logic [23:0] wr_q[$];
   int          cyc = 0, txwr_cyc = 0, go_cyc = 0, go_cnt = 0, viol = 0;
   logic [15:0] go_addr_seen = 16'h0;
   logic        mem_we_d = 1'b0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (uart_cs && uart_rnw && uart_a0) rx_clr <= rx_clr + 1;
      if (uart_cs && !uart_rnw && uart_a0) begin
         tx_q.push_back(uart_din);
         tx_busy_cnt <= int'($urandom_range(0, 6));
         txwr_cyc    <= cyc;
      end else if (tx_busy_cnt != 0) begin
         tx_busy_cnt <= tx_busy_cnt - 1;
      end
      if (mem_we) wr_q.push_back({mem_addr, mem_dout});
      viol     <= viol + int'(mem_we && uart_cs) + int'(mem_we && mem_we_d);
      mem_we_d <= mem_we;
      if (go) begin
         go_cnt       <= go_cnt + 1;
         go_addr_seen <= go_addr;
         go_cyc       <= cyc;
      end
   end

   int          tx_rd = 0, wr_rd = 0, go_rd = 0;
   logic [7:0]  fdata[$];
   localparam logic [53:0] RST_VEC = {1'b0, 1'b1, 1'b0, 8'h00, 16'h0, 8'h00, 1'b0, 1'b0, 16'h0, 1'b0};

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int t = 0;
      while (rx_full && t < 200) begin
         tick(1);
         t++;
      end
      chk("rx_drain", rx_full, 1'b0);
      rx_data = b;
      rx_set  = rx_set + 1;
      tick(int'($urandom_range(1, 3)));
   endtask

   task automatic wait_reply(input string tag, input logic [7:0] exp);
      int t = 0;
      while (tx_q.size() <= tx_rd && t < 400) begin
         tick(1);
         t++;
      end
      chk({tag, "_cnt"}, tx_q.size(), tx_rd + 1);
      if (tx_q.size() > tx_rd) begin
         chk(tag, tx_q[tx_rd], exp);
         tx_rd++;
      end
   endtask

   // Load frame from fdata; expectations come from address/checksum arithmetic.
   task automatic load_frame(input logic [15:0] a, input bit force_sum,
                             input logic [7:0] sum_val, input int bad_ofs);
      int         s = 0;
      int         len = fdata.size();
      logic [7:0] sent, exp_reply;
      foreach (fdata[i]) s += int'(fdata[i]);
      sent      = force_sum ? sum_val : 8'((s + bad_ofs) % 256);
      exp_reply = (sent == 8'(s % 256)) ? 8'h06 : 8'h15;
      send(8'h4C);
      send(a[15:8]);
      send(a[7:0]);
      send(8'(len));
      for (int i = 0; i < len; i++) send(fdata[i]);
      send(sent);
      wait_reply("reply", exp_reply);
      chk("wr_count", wr_q.size(), wr_rd + len);
      for (int i = 0; i < len; i++) begin
         if (wr_rd < wr_q.size()) chk("wr", wr_q[wr_rd], {16'(int'(a) + i), fdata[i]});
         wr_rd++;
      end
      tick(3);
      chk("busy_idle", busy, 1'b0);
   endtask

   task automatic go_frame(input logic [15:0] a);
      int t = 0;
      send(8'h47);
      send(a[15:8]);
      send(a[7:0]);
      wait_reply("go_ack", 8'h06);
      while (go_cnt == go_rd && t < 50) begin
         tick(1);
         t++;
      end
      chk("go_pulse", go_cnt, go_rd + 1);
      chk("go_addr_at_pulse", go_addr_seen, a);
      chk("go_after_txwr", go_cyc, txwr_cyc + 1);
      tick(4);
      chk("go_one_cycle", go_cnt, go_rd + 1);
      chk("go_addr_held", go_addr, a);
      go_rd = go_cnt;
   endtask

   initial begin
      int t;
      tick(2);
      chk("rst_outs", {uart_cs, uart_rnw, uart_a0, uart_din, mem_addr, mem_dout,
                       mem_we, go, go_addr, busy}, RST_VEC);
      reset = 1'b1;
      tick(2);

      fdata = '{8'hAA, 8'hBB, 8'hCC};
      load_frame(16'h1234, 1'b0, 8'h00, 0);
      load_frame(16'h1234, 1'b1, 8'h00, 0);

      fdata.delete();
      for (int i = 0; i < 256; i++) fdata.push_back(8'h01);
      load_frame(16'hFFFF, 1'b1, 8'h00, 0);

      go_frame(16'h8000);

      send(8'h4C);
      send(8'h12);
      tick(TMO + 10);
      chk("tmo_busy", busy, 1'b0);
      chk("tmo_no_reply", tx_q.size(), tx_rd);
      chk("tmo_no_write", wr_q.size(), wr_rd);
      go_frame(16'h0010);

      for (int f = 0; f < 6; f++) begin
         int n = int'($urandom_range(1, 16));
         fdata.delete();
         for (int i = 0; i < n; i++) fdata.push_back(8'($urandom));
         load_frame(16'($urandom), 1'b0, 8'h00,
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 255)) : 0);
      end

      send(8'h00);
      tick(10);
      chk("junk_busy", busy, 1'b0);
      chk("junk_no_reply", tx_q.size(), tx_rd);

      send(8'h4C);
      send(8'h00);
      send(8'h00);
      send(8'h05);
      send(8'h01);
      t = 0;
      while (wr_q.size() <= wr_rd && t < 50) begin
         tick(1);
         t++;
      end
      chk("partial_wr_cnt", wr_q.size(), wr_rd + 1);
      if (wr_q.size() > wr_rd) chk("partial_wr", wr_q[wr_rd], 24'h000001);
      wr_rd = wr_q.size();
      #2 reset = 1'b0;
      #1;
      chk("midframe_rst_outs", {uart_cs, uart_rnw, uart_a0, uart_din, mem_addr, mem_dout,
                                mem_we, go, go_addr, busy}, RST_VEC);
      tick(2);
      reset = 1'b1;
      tick(2);
      chk("post_rst_busy", busy, 1'b0);
      go_frame(16'h0000);

      chk("we_cs_overlap_or_wide_we", viol, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
